rot_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit barrel rotator. Each requester presents a byte, a rotate amount and a direction over a valid/ready handshake. The block grants one request per cycle, drives the rotator, and registers the result into a single response slot tagged with the winner's ID. It sits between the two client datapaths and the single rotator instance, so neither client touches the rotator directly.

---
 rtl/rot_pkg.sv | 16 +
 rtl/rot8.sv | 24 ++
 rtl/rot_arbiter.sv | 108 ++++++++++
 tb/tb_rot_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotator arbiter: widths, requester IDs and
// the response-slot state encoding.
package rot_pkg;

   localparam int ROT_W = 8;
   localparam int AMT_W = 3;

   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/rot8.sv
// Combinational 8-bit barrel rotator. A right rotate by k is performed as a
// left rotate by (8-k) mod 8, so one chain of left-rotate stages (1, 2, 4)
// serves both directions.
module rot8
   import rot_pkg::*;
(
   input  logic [ROT_W-1:0] data,
   input  logic [AMT_W-1:0] amt,
   input  logic             dir,
   output logic [ROT_W-1:0] out
);

   logic [AMT_W-1:0] left_amt;
   logic [ROT_W-1:0] stage1;
   logic [ROT_W-1:0] stage2;

   // dir = 1 (right) becomes the equivalent left amount; wraps naturally mod 8.
   assign left_amt = dir ? ({AMT_W{1'b0}} - amt) : amt;

   assign stage1 = left_amt[0] ? {data[ROT_W-2:0], data[ROT_W-1]}       : data;
   assign stage2 = left_amt[1] ? {stage1[ROT_W-3:0], stage1[ROT_W-1:ROT_W-2]} : stage1;
   assign out    = left_amt[2] ? {stage2[ROT_W-5:0], stage2[ROT_W-1:ROT_W-4]} : stage2;

endmodule

// File: rtl/rot_arbiter.sv
// Two-requester arbiter in front of the shared rot8 rotator, with a single
// registered response slot tagged by winner ID.
// Build option: define ROT_ARB_RR_EN for round-robin tie breaking; without it
// A always wins ties and no priority register exists.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Ready is a pure function of the other side's state plus the
// valids (never the payload); a requester may withdraw valid at any time
// before the transfer. The response side follows the same rule with
// rsp_valid from this block and rsp_ready from the consumer.
module rot_arbiter
   import rot_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,

   input  logic             a_valid,
   output logic             a_ready,
   input  logic [ROT_W-1:0] a_data,
   input  logic [AMT_W-1:0] a_amt,
   input  logic             a_dir,

   input  logic             b_valid,
   output logic             b_ready,
   input  logic [ROT_W-1:0] b_data,
   input  logic [AMT_W-1:0] b_amt,
   input  logic             b_dir,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ROT_W-1:0] rsp_data,
   output logic             rsp_id,

   output logic             dbg_state
);

   slot_state_e      state_q;
   logic [ROT_W-1:0] data_q;
   logic             id_q;

   logic             can_load;
   logic             win_b;
   logic             accept;

   logic [ROT_W-1:0] sel_data;
   logic [AMT_W-1:0] sel_amt;
   logic             sel_dir;
   logic [ROT_W-1:0] rot_out;

`ifdef ROT_ARB_RR_EN
   logic prio_q;

   // Tie goes to the requester named by prio; a lone requester always wins.
   assign win_b = b_valid & (~a_valid | (prio_q == ID_B));

   // After every accept the loser gets priority for the next tie.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prio_q <= ID_A;
      end else if (accept) begin
         prio_q <= win_b ? ID_A : ID_B;
      end
   end
`else
   // Fixed priority: B only wins when A is idle.
   assign win_b = b_valid & ~a_valid;
`endif

   // Slot can take a new result when empty or when its current one leaves now.
   assign can_load = reset_n & ((state_q == EMPTY) | rsp_ready);

   assign a_ready = can_load & a_valid & ~win_b;
   assign b_ready = can_load & win_b;
   assign accept  = a_ready | b_ready;

   // Rotator operands come from whichever requester is granted.
   assign sel_data = win_b ? b_data : a_data;
   assign sel_amt  = win_b ? b_amt  : a_amt;
   assign sel_dir  = win_b ? b_dir  : a_dir;

   rot8 u_rot8 (
      .data (sel_data),
      .amt  (sel_amt),
      .dir  (sel_dir),
      .out  (rot_out)
   );

   // Response slot FSM: load on accept (even while popping), else drain on pop.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         id_q    <= ID_A;
      end else if (accept) begin
         state_q <= FULL;
         data_q  <= rot_out;
         id_q    <= win_b ? ID_B : ID_A;
      end else if (rsp_ready) begin
         state_q <= EMPTY;
      end
   end

   assign rsp_valid = (state_q == FULL);
   assign rsp_data  = data_q;
   assign rsp_id    = id_q;
   assign dbg_state = logic'(state_q);

endmodule

// File: tb/tb_rot_arbiter.sv
// Self-checking bench for rot_arbiter. A small reference model predicts
// ready outputs and slot occupancy; expected responses are queued on
// accept and compared when the consumer takes them.
module tb_rot_arbiter;

`ifdef ROT_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic       a_valid, a_ready, a_dir;
   logic [7:0] a_data;
   logic [2:0] a_amt;
   logic       b_valid, b_ready, b_dir;
   logic [7:0] b_data;
   logic [2:0] b_amt;
   logic       rsp_valid, rsp_ready, rsp_id;
   logic [7:0] rsp_data;
   logic       dbg_state;

   int errors = 0;
   int checks = 0;

   logic [8:0] exp_q[$];
   logic       m_full;
   logic       m_prio;

   rot_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_data    (a_data),
      .a_amt     (a_amt),
      .a_dir     (a_dir),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_data    (b_data),
      .b_amt     (b_amt),
      .b_dir     (b_dir),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference helpers ----------------
   function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic [2:0] k, input logic right);
      logic [15:0] t;
      if (right) begin
         t = {d, d} >> k;
         return t[7:0];
      end
      t = {d, d} << k;
      return t[15:8];
   endfunction

   function automatic void predict(output logic ea, output logic eb);
      logic can, wb;
      can = reset_n && (!m_full || rsp_ready);
      wb  = b_valid && (!a_valid || (RR && m_prio));
      ea  = can && a_valid && !wb;
      eb  = can && wb;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply(input logic av, input logic [7:0] ad, input logic [2:0] aa, input logic adr,
                        input logic bv, input logic [7:0] bd, input logic [2:0] ba, input logic bdr,
                        input logic rr);
      a_valid = av; a_data = ad; a_amt = aa; a_dir = adr;
      b_valid = bv; b_data = bd; b_amt = ba; b_dir = bdr;
      rsp_ready = rr;
      #2;
   endtask

   // Advance the model across the next rising edge, queueing any accepted op.
   task automatic commit(input logic ea, input logic eb);
      if (ea) exp_q.push_back({1'b0, ref_rot(a_data, a_amt, a_dir)});
      if (eb) exp_q.push_back({1'b1, ref_rot(b_data, b_amt, b_dir)});
      if (!reset_n) begin
         m_full = 1'b0;
         m_prio = 1'b0;
         exp_q.delete();
      end else if (ea || eb) begin
         m_full = 1'b1;
         m_prio = ea;
      end else if (rsp_ready) begin
         m_full = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
      m_full = 1'b0;
      m_prio = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [8:0] exp;
      #3;
      if (reset_n && rsp_valid && rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got id=%0d data=%02h, required no response", rsp_id, rsp_data);
         end else begin
            exp = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== exp) begin
               errors++;
               $display("FAIL rsp_result: got id=%0d data=%02h, required id=%0d data=%02h",
                        rsp_id, rsp_data, exp[8], exp[7:0]);
            end
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      m_full = 1'b0; m_prio = 1'b0; exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         apply(1, 8'h81, 1, 0, 0, 8'h00, 0, 0, 1);
         checks++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a=%0b b=%0b, required a=0 b=0", a_ready, b_ready);
         end
         @(negedge clk);
         #2;
         checks++;
         if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 1'b0 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%0b d=%02h id=%0b st=%0b, required 0/00/0/0",
                     rsp_valid, rsp_data, rsp_id, dbg_state);
         end
         @(negedge clk);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      logic ea, eb;
      apply(1, 8'h81, 1, 0, 0, 8'h00, 0, 0, 1);
      predict(ea, eb);
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_ready: got a=%0b b=%0b, required a=1 b=0", a_ready, b_ready);
      end
      commit(ea, eb);
      apply(1, 8'h01, 3, 1, 0, 8'h00, 0, 0, 1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h03 || rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL single_rotl: got v=%0b d=%02h id=%0b, required v=1 d=03 id=0", rsp_valid, rsp_data, rsp_id);
      end
      predict(ea, eb);
      commit(ea, eb);
      apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h20 || rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL single_rotr: got v=%0b d=%02h id=%0b, required v=1 d=20 id=0", rsp_valid, rsp_data, rsp_id);
      end
      predict(ea, eb);
      commit(ea, eb);
      apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got v=%0b, required v=0", rsp_valid);
      end
   endtask

   task automatic test_tie();
      logic ea, eb, exp_b;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply(1, 8'h11 + 8'(i), 3'(i), 0, 1, 8'hC3 + 8'(i), 3'(i + 1), 1, 1);
         predict(ea, eb);
         exp_b = RR ? ((i % 2) == 1) : 1'b0;
         checks++;
         if (b_ready !== exp_b || a_ready !== !exp_b) begin
            errors++;
            $display("FAIL tie_grant[%0d]: got a=%0b b=%0b, required a=%0b b=%0b", i, a_ready, b_ready, !exp_b, exp_b);
         end
         if (i > 0) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== (RR ? ((i % 2) == 0) : 1'b0)) begin
               errors++;
               $display("FAIL tie_id[%0d]: got v=%0b id=%0b", i - 1, rsp_valid, rsp_id);
            end
         end
         commit(ea, eb);
      end
      apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
      predict(ea, eb);
      commit(ea, eb);
   endtask

   task automatic test_backpressure();
      logic ea, eb;
      apply(1, 8'h5A, 2, 0, 0, 8'h00, 0, 0, 1);
      predict(ea, eb);
      commit(ea, eb);
      for (int i = 0; i < 5; i++) begin
         apply(1, 8'h33, 1, 1, 1, 8'h66, 5, 0, 0);
         predict(ea, eb);
         checks++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'h69) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got a=%0b b=%0b v=%0b d=%02h, required 0 0 1 69",
                     i, a_ready, b_ready, rsp_valid, rsp_data);
         end
         commit(ea, eb);
      end
      apply(0, 8'h00, 0, 0, 1, 8'h96, 4, 1, 1);
      predict(ea, eb);
      checks++;
      if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got a=%0b b=%0b, required a=0 b=1", a_ready, b_ready);
      end
      commit(ea, eb);
      apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h69 || rsp_id !== 1'b1) begin
         errors++;
         $display("FAIL bp_b_result: got v=%0b d=%02h id=%0b, required v=1 d=69 id=1", rsp_valid, rsp_data, rsp_id);
      end
      predict(ea, eb);
      commit(ea, eb);
      apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
      predict(ea, eb);
      commit(ea, eb);
   endtask

   task automatic test_sweep();
      logic ea, eb;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 8; k++) begin
            apply(1, 8'hA5, 3'(k), d[0], 0, 8'h00, 0, 0, 1);
            predict(ea, eb);
            checks++;
            if (a_ready !== ea || b_ready !== eb) begin
               errors++;
               $display("FAIL sweep_ready: got a=%0b b=%0b, required a=%0b b=%0b", a_ready, b_ready, ea, eb);
            end
            commit(ea, eb);
            if (k == 0) begin
               #2;
               checks++;
               if (rsp_data !== 8'hA5) begin
                  errors++;
                  $display("FAIL sweep_amt0 dir=%0d: got %02h, required a5", d, rsp_data);
               end
            end
         end
      end
      apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
      predict(ea, eb);
      commit(ea, eb);
   endtask

   task automatic test_random();
      logic ea, eb;
      for (int i = 0; i < 60; i++) begin
         apply(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
         predict(ea, eb);
         checks++;
         if (a_ready !== ea || b_ready !== eb || rsp_valid !== m_full) begin
            errors++;
            $display("FAIL random_ctl[%0d]: got a=%0b b=%0b v=%0b, required a=%0b b=%0b v=%0b",
                     i, a_ready, b_ready, rsp_valid, ea, eb, m_full);
         end
         commit(ea, eb);
      end
      for (int i = 0; i < 2; i++) begin
         apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
         predict(ea, eb);
         commit(ea, eb);
      end
   endtask

   task automatic test_mid_reset();
      logic ea, eb;
      apply(0, 8'h00, 0, 0, 1, 8'hF0, 2, 1, 1);
      predict(ea, eb);
      commit(ea, eb);
      apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1);
      reset_n = 1'b0;
      predict(ea, eb);
      commit(ea, eb);
      reset_n = 1'b1;
      apply(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got v=%0b d=%02h id=%0b, required v=0 d=00 id=0", rsp_valid, rsp_data, rsp_id);
      end
      predict(ea, eb);
      commit(ea, eb);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset_n = 1'b0;
      a_valid = 0; a_data = 0; a_amt = 0; a_dir = 0;
      b_valid = 0; b_data = 0; b_amt = 0; b_dir = 0;
      rsp_ready = 0;
      m_full = 1'b0;
      m_prio = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_sweep();
      test_random();
      test_mid_reset();
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending results, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
